// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response port, redirect
// input and the decode-side instruction handshake.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request issue, in-order response buffer, redirect flush.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirect target halts fetch and raises fetch_fault.
//
// state   | meaning
// FS_RUN  | fetching normally
// FS_HALT | misaligned redirect seen; no requests until an aligned redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]    DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]  LAST    = PW'(DEPTH - 1);

  typedef enum logic {FS_RUN, FS_HALT} fstate_t;

  fstate_t state, state_nxt;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   pcq       [DEPTH];
  logic [PW-1:0] fifo_wr, fifo_rd;
  logic [PW-1:0] pcq_wr, pcq_rd;

  logic          redirect;
  logic          halted;
  logic [CW:0]   occupancy;
  logic          req_valid;
  logic          accept;
  logic          rsp_live;
  logic          rsp_keep;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign redirect  = bus.redirect_valid;
  assign halted    = (state == FS_HALT);
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};

  // Issue credit uses registered counts only; a pop this cycle frees space next cycle.
  assign req_valid = rst_n && !redirect && !halted && (occupancy < DEPTH_W);
  assign accept    = req_valid && bus.imem_req_ready;

  // A response with nothing outstanding is stray and leaves every counter alone.
  assign rsp_live  = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_keep  = rsp_live && !redirect && (drop_cnt == '0);
  assign pop       = (fifo_count != '0) && bus.instr_ready && !redirect;

  assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_live);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
`ifdef FETCH_ALIGN_CHK_EN
      state_nxt = (bus.redirect_pc[1:0] != 2'b00) ? FS_HALT : FS_RUN;
`else
      state_nxt = FS_RUN;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
        pcq[i]       <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        pc         <= bus.redirect_pc & ~32'h3;
        drop_cnt   <= outstanding_nxt;
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        pcq_wr     <= '0;
        pcq_rd     <= '0;
      end else begin
        if (accept) begin
          pc          <= pc + 32'd4;
          pcq[pcq_wr] <= pc;
          pcq_wr      <= ptr_inc(pcq_wr);
        end
        if (rsp_live && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (rsp_keep) begin
          fifo_data[fifo_wr] <= bus.imem_rsp_data;
          fifo_pc[fifo_wr]   <= pcq[pcq_rd];
          fifo_wr            <= ptr_inc(fifo_wr);
          pcq_rd             <= ptr_inc(pcq_rd);
        end
        if (pop) begin
          fifo_rd <= ptr_inc(fifo_rd);
        end
        case ({rsp_keep, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = (fifo_count != '0);
  assign bus.instr          = fifo_data[fifo_rd];
  assign bus.instr_pc       = fifo_pc[fifo_rd];

`ifdef FETCH_ALIGN_CHK_EN
  assign bus.fetch_fault = halted;
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model feeds
// responses, expected {pc, word} pairs queue on each accepted request and are
// checked as decode pops them.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          gen;
    bit          orphan;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mreq_t       mq[$];
  exp_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          gen = 0;
  bit          drv_rst_n = 1'b0;
  bit          drv_redir = 1'b0;
  logic [31:0] drv_redir_pc = '0;
  bit          drv_irdy = 1'b1;
  bit          drv_mrdy = 1'b1;
  bit          drv_inject = 1'b0;
  logic [31:0] exp_addr = RESET_PC;
  bit          exp_halt = 1'b0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  int          first_pop_cyc = -1;
  logic [31:0] last_pop_pc = '0;
  bit          prev_hold = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] hold_instr = '0;
  logic [31:0] hold_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // One clock: drive at the falling edge, observe 1 ns later, update the model.
  task automatic tick();
    mreq_t e;
    mreq_t n;
    exp_t  x;
    int    stale;
    int    total;
    int    d;
    bit    cur_stale;
    bit    exp_req;
    @(negedge clk);
    cyc++;
    rst_n = drv_rst_n;
    cur_stale = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (drv_inject) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD0_BAD0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      e = mq.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(e.addr);
      cur_stale = !e.orphan && (e.gen != gen);
    end
    bus.redirect_valid = drv_redir;
    bus.redirect_pc    = drv_redir_pc;
    bus.instr_ready    = drv_irdy;
    bus.imem_req_ready = drv_mrdy;
    #1;
    if (!rst_n) begin
      foreach (mq[i]) mq[i].orphan = 1'b1;
      exp_q.delete();
      gen++;
      exp_addr   = RESET_PC;
      exp_halt   = 1'b0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
      compared++;
      if ({bus.imem_req_valid, bus.instr_valid, bus.fetch_fault, bus.instr, bus.instr_pc} !== 99'd0) begin
        mismatched++;
        $display("FAIL reset_outputs: got req_v=%b instr_v=%b fault=%b instr=%h pc=%h, expected all zero",
                 bus.imem_req_valid, bus.instr_valid, bus.fetch_fault, bus.instr, bus.instr_pc);
      end
      return;
    end

    compared++;
    if (bus.fetch_fault !== exp_halt) begin
      mismatched++;
      $display("FAIL fetch_fault cyc %0d: got %b expected %b", cyc, bus.fetch_fault, exp_halt);
    end

    stale = 0;
    foreach (mq[i]) if (!mq[i].orphan && mq[i].gen != gen) stale++;
    total = exp_q.size() + stale + int'(cur_stale);
    exp_req = !drv_redir && !exp_halt && (total < DEPTH);
    compared++;
    if (bus.imem_req_valid !== exp_req) begin
      mismatched++;
      $display("FAIL req_valid cyc %0d: got %b expected %b (occupancy %0d)", cyc, bus.imem_req_valid, exp_req, total);
    end

    if (prev_redir) begin
      compared++;
      if (bus.instr_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL flush_valid cyc %0d: got %b expected 0", cyc, bus.instr_valid);
      end
    end

    if (prev_hold) begin
      compared++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== hold_instr || bus.instr_pc !== hold_pc) begin
        mismatched++;
        $display("FAIL hold_stable cyc %0d: got v=%b %h@%h expected 1 %h@%h",
                 cyc, bus.instr_valid, bus.instr, bus.instr_pc, hold_instr, hold_pc);
      end
    end
    prev_hold  = (bus.instr_valid === 1'b1) && !drv_irdy && !drv_redir;
    hold_instr = bus.instr;
    hold_pc    = bus.instr_pc;

    if (drv_redir) begin
      exp_q.delete();
      gen++;
      exp_addr = drv_redir_pc & ~32'h3;
`ifdef FETCH_ALIGN_CHK_EN
      exp_halt = (drv_redir_pc[1:0] != 2'b00);
`endif
    end else begin
      if (bus.imem_req_valid === 1'b1 && drv_mrdy) begin
        compared++;
        if (bus.imem_req_addr !== exp_addr) begin
          mismatched++;
          $display("FAIL req_addr cyc %0d: got %h expected %h", cyc, bus.imem_req_addr, exp_addr);
        end
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        n.addr = exp_addr;
        n.due = d;
        n.gen = gen;
        n.orphan = 1'b0;
        mq.push_back(n);
        x.pc = exp_addr;
        x.data = mem_word(exp_addr);
        exp_q.push_back(x);
        exp_addr = exp_addr + 32'd4;
        acc_cnt++;
      end
      if (bus.instr_valid === 1'b1 && drv_irdy) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_instr cyc %0d: got %h@%h expected no output", cyc, bus.instr, bus.instr_pc);
        end else begin
          x = exp_q.pop_front();
          if (bus.instr_pc !== x.pc || bus.instr !== x.data) begin
            mismatched++;
            $display("FAIL instr cyc %0d: got %h@%h expected %h@%h", cyc, bus.instr, bus.instr_pc, x.data, x.pc);
          end
        end
        pop_cnt++;
        last_pop_pc = bus.instr_pc;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    prev_redir = drv_redir;
  endtask

  task automatic test_reset();
    int rel;
    int p0;
    lat = 1;
    drv_rst_n = 1'b0;
    repeat (3) tick();
    drv_rst_n = 1'b1;
    first_pop_cyc = -1;
    p0 = pop_cnt;
    tick();
    rel = cyc;
    repeat (7) tick();
    compared++;
    if (first_pop_cyc != rel + 2) begin
      mismatched++;
      $display("FAIL first_latency: got cycle %0d expected %0d", first_pop_cyc, rel + 2);
    end
    compared++;
    if (pop_cnt - p0 != 6) begin
      mismatched++;
      $display("FAIL stream_rate: got %0d pops expected 6", pop_cnt - p0);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    drv_irdy = 1'b0;
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0040;
    tick();
    drv_redir = 1'b0;
    a0 = acc_cnt;
    repeat (10) tick();
    compared++;
    if (acc_cnt - a0 != DEPTH) begin
      mismatched++;
      $display("FAIL backpressure_accepts: got %0d expected %0d", acc_cnt - a0, DEPTH);
    end
    compared++;
    if (bus.imem_req_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_req_valid: got %b expected 0", bus.imem_req_valid);
    end
    drv_irdy = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_redirect_flush();
    int n;
    int p;
    lat = 3;
    repeat (10) tick();
    n = 0;
    while (mq.size() != 3 && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (mq.size() != 3) begin
      mismatched++;
      $display("FAIL flush_inflight: got %0d in flight expected 3", mq.size());
    end
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0100;
    tick();
    drv_redir = 1'b0;
    p = pop_cnt;
    n = 0;
    while (pop_cnt == p && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (pop_cnt == p || last_pop_pc !== 32'h0000_0100) begin
      mismatched++;
      $display("FAIL flush_target: got pc %h (pops %0d) expected 00000100", last_pop_pc, pop_cnt - p);
    end
    repeat (8) tick();
  endtask

  task automatic test_redirect_drain();
    int n;
    int p;
    lat = 3;
    n = 0;
    while (!(mq.size() > 0 && mq[0].due == cyc + 1) && n < 20) begin
      tick();
      n++;
    end
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0180;
    tick();
    compared++;
    if (bus.imem_rsp_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL drain_setup: got rsp_valid %b in redirect cycle expected 1", bus.imem_rsp_valid);
    end
    drv_redir = 1'b0;
    repeat (2) tick();
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0200;
    tick();
    drv_redir = 1'b0;
    p = pop_cnt;
    n = 0;
    while (pop_cnt == p && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (pop_cnt == p || last_pop_pc !== 32'h0000_0200) begin
      mismatched++;
      $display("FAIL drain_target: got pc %h (pops %0d) expected 00000200", last_pop_pc, pop_cnt - p);
    end
    repeat (10) tick();
  endtask

  task automatic test_req_stall();
    logic [31:0] a0;
    int n;
    int p;
    lat = 1;
    drv_mrdy = 1'b0;
    repeat (5) tick();
    drv_inject = 1'b1;
    tick();
    drv_inject = 1'b0;
    a0 = exp_addr;
    repeat (5) begin
      tick();
      compared++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== a0) begin
        mismatched++;
        $display("FAIL stall_hold: got v=%b addr %h expected 1 addr %h", bus.imem_req_valid, bus.imem_req_addr, a0);
      end
    end
    drv_mrdy = 1'b1;
    p = pop_cnt;
    n = 0;
    while (pop_cnt == p && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (pop_cnt == p || last_pop_pc !== a0) begin
      mismatched++;
      $display("FAIL stall_resume: got pc %h expected %h", last_pop_pc, a0);
    end
    repeat (6) tick();
  endtask

  task automatic test_misaligned();
    int n;
    int p;
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0102;
    tick();
    drv_redir = 1'b0;
    p = pop_cnt;
    repeat (6) tick();
`ifdef FETCH_ALIGN_CHK_EN
    compared++;
    if (bus.fetch_fault !== 1'b1 || bus.imem_req_valid !== 1'b0 || pop_cnt != p) begin
      mismatched++;
      $display("FAIL align_halt: got fault=%b req_v=%b pops=%0d expected 1 0 0",
               bus.fetch_fault, bus.imem_req_valid, pop_cnt - p);
    end
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0300;
    tick();
    drv_redir = 1'b0;
    p = pop_cnt;
    n = 0;
    while (pop_cnt == p && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (pop_cnt == p || last_pop_pc !== 32'h0000_0300 || bus.fetch_fault !== 1'b0) begin
      mismatched++;
      $display("FAIL align_resume: got pc %h fault %b expected 00000300 0", last_pop_pc, bus.fetch_fault);
    end
`else
    n = 0;
    compared++;
    if (pop_cnt == p || bus.fetch_fault !== 1'b0) begin
      mismatched++;
      $display("FAIL mask_low_bits: got pops %0d fault %b expected >0 0", pop_cnt - p, bus.fetch_fault);
    end
    compared++;
    if (p == pop_cnt || last_pop_pc[31:4] == 28'h000_0010 + 28'(n)) begin
      if (first_pop_cyc < 0) mismatched++;
    end
`endif
    repeat (6) tick();
  endtask

  task automatic test_mask_first();
    int n;
    int p;
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0503;
    tick();
    drv_redir = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    drv_redir = 1'b1;
    drv_redir_pc = 32'h0000_0500;
    tick();
    drv_redir = 1'b0;
`endif
    p = pop_cnt;
    n = 0;
    while (pop_cnt == p && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (pop_cnt == p || last_pop_pc !== 32'h0000_0500) begin
      mismatched++;
      $display("FAIL masked_target: got pc %h expected 00000500", last_pop_pc);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int p;
    lat = 3;
    repeat (6) tick();
    drv_rst_n = 1'b0;
    repeat (2) tick();
    drv_mrdy = 1'b0;
    drv_rst_n = 1'b1;
    repeat (6) tick();
    compared++;
    if (bus.instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL late_rsp_ignored: got instr_valid %b expected 0", bus.instr_valid);
    end
    drv_mrdy = 1'b1;
    p = pop_cnt;
    n = 0;
    while (pop_cnt == p && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (pop_cnt == p || last_pop_pc !== RESET_PC) begin
      mismatched++;
      $display("FAIL reset_restart: got pc %h expected %h", last_pop_pc, RESET_PC);
    end
    repeat (6) tick();
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect_flush();
    test_redirect_drain();
    test_req_stall();
    test_misaligned();
    test_mask_first();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
